// File: rtl/user_wb_timer_slave_if.sv
// Wishbone classic bus bundle between the management core's user-project master
// and the timer responder in the user area.
interface user_wb_timer_slave_if;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_we_i;
    logic [3:0]  wb_sel_i;
    logic [31:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic        wb_ack_o;
    logic [31:0] wb_dat_o;

    modport master (
        output wb_cyc_i,
        output wb_stb_i,
        output wb_we_i,
        output wb_sel_i,
        output wb_adr_i,
        output wb_dat_i,
        input  wb_ack_o,
        input  wb_dat_o
    );

    modport slave (
        input  wb_cyc_i,
        input  wb_stb_i,
        input  wb_we_i,
        input  wb_sel_i,
        input  wb_adr_i,
        input  wb_dat_i,
        output wb_ack_o,
        output wb_dat_o
    );
endinterface

// File: rtl/user_wb_timer_slave.sv
// Wishbone classic responder with programmable wait states, exposing a small
// register file around a 32-bit compare timer that raises a level interrupt.
module user_wb_timer_slave #(
    parameter logic [31:0] BASE_ADR    = 32'h3000_0000,
    parameter int unsigned WAIT_STATES = 1,
    parameter logic [31:0] ID_VALUE    = 32'hCA1A_0001
) (
    input  logic                  core_clk,
    input  logic                  core_rstn,
    user_wb_timer_slave_if.slave  wb,
    output logic                  irq_o
);

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

    localparam logic [5:0] OFF_CTRL    = 6'h00;
    localparam logic [5:0] OFF_STATUS  = 6'h01;
    localparam logic [5:0] OFF_COMPARE = 6'h02;
    localparam logic [5:0] OFF_COUNT   = 6'h03;
    localparam logic [5:0] OFF_SCRATCH = 6'h04;
    localparam logic [5:0] OFF_ID      = 6'h05;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    // Bus-side state
    state_t      state_q, state_d;
    logic [3:0]  wait_q, wait_d;
    logic        we_q, we_d;
    logic [3:0]  sel_q, sel_d;
    logic [5:0]  off_q, off_d;
    logic [31:0] wdat_q, wdat_d;
    logic        ack_q, ack_d;
    logic [31:0] rdat_q, rdat_d;

    // Register file / timer state
    logic        en_q, en_d;
    logic        per_q, per_d;
    logic        ie_q, ie_d;
    logic        pend_q, pend_d;
    logic [31:0] compare_q, compare_d;
    logic [31:0] count_q, count_d;
    logic [31:0] scratch_q, scratch_d;
    logic        irq_q, irq_d;

    logic        req;
    logic        cyc_stb;
    logic        wr_en;
    logic        match;
    logic [5:0]  rd_off;
    logic [31:0] rd_val;
    logic [31:0] lane_mask;
    logic        unused_adr_lsbs;

    assign cyc_stb = wb.wb_cyc_i & wb.wb_stb_i;
    assign req     = cyc_stb & (wb.wb_adr_i[31:8] == BASE_ADR[31:8]);
    assign unused_adr_lsbs = ^wb.wb_adr_i[1:0];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign lane_mask[8*gi +: 8] = {8{sel_q[gi]}};
        end
    endgenerate

    // ------------------------------------------------------------------
    // Bus handshake FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        we_d    = we_q;
        sel_d   = sel_q;
        off_d   = off_q;
        wdat_d  = wdat_q;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    we_d   = wb.wb_we_i;
                    sel_d  = wb.wb_sel_i;
                    off_d  = wb.wb_adr_i[7:2];
                    wdat_d = wb.wb_dat_i;
                    if (WAIT_STATES == 0) begin
                        state_d = ST_ACK;
                    end else begin
                        state_d = ST_WAIT;
                        wait_d  = WAIT_LOAD;
                    end
                end
            end
            ST_WAIT: begin
                // A master that gives up mid-wait gets neither ack nor write.
                if (!cyc_stb) begin
                    state_d = ST_IDLE;
                end else if (wait_q == 4'd1) begin
                    state_d = ST_ACK;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // With zero wait states the read is captured on the sampling edge, before
    // the offset has been latched, so the mux must look at the live address.
    assign rd_off = (state_q == ST_IDLE) ? wb.wb_adr_i[7:2] : off_q;

    always_comb begin
        rd_val = 32'd0;
        case (rd_off)
            OFF_CTRL:    rd_val = {29'd0, ie_q, per_q, en_q};
            OFF_STATUS:  rd_val = {30'd0, en_q, pend_q};
            OFF_COMPARE: rd_val = compare_q;
            OFF_COUNT:   rd_val = count_q;
            OFF_SCRATCH: rd_val = scratch_q;
            OFF_ID:      rd_val = ID_VALUE;
            default:     rd_val = 32'd0;
        endcase
    end

    assign ack_d  = (state_d == ST_ACK);
    assign rdat_d = ack_d ? rd_val : 32'd0;
    assign wr_en  = (state_q == ST_ACK) && we_q;

    // ------------------------------------------------------------------
    // Register writes and timer
    // ------------------------------------------------------------------
    assign match = en_q && (count_q == compare_q);

    always_comb begin
        en_d      = en_q;
        per_d     = per_q;
        ie_d      = ie_q;
        pend_d    = pend_q;
        compare_d = compare_q;
        count_d   = count_q;
        scratch_d = scratch_q;

        if (en_q) begin
            if (match) begin
                if (per_q) begin
                    count_d = 32'd0;
                end else begin
                    en_d = 1'b0;
                end
            end else begin
                count_d = count_q + 32'd1;
            end
        end

        // Bus writes are applied after the timer so they override it.
        if (wr_en) begin
            case (off_q)
                OFF_CTRL: begin
                    if (sel_q[0]) begin
                        en_d  = wdat_q[0];
                        per_d = wdat_q[1];
                        ie_d  = wdat_q[2];
                    end
                end
                OFF_STATUS: begin
                    if (sel_q[0] && wdat_q[0]) begin
                        pend_d = 1'b0;
                    end
                end
                OFF_COMPARE: compare_d = (compare_q & ~lane_mask) | (wdat_q & lane_mask);
                OFF_COUNT:   count_d   = (count_q   & ~lane_mask) | (wdat_q & lane_mask);
                OFF_SCRATCH: scratch_d = (scratch_q & ~lane_mask) | (wdat_q & lane_mask);
                default: ;
            endcase
        end

        // A match outranks a simultaneous write-1-to-clear.
        if (match) begin
            pend_d = 1'b1;
        end
    end

    assign irq_d = pend_d & ie_d;

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge core_clk or negedge core_rstn) begin
        if (!core_rstn) begin
            state_q   <= ST_IDLE;
            wait_q    <= 4'd0;
            we_q      <= 1'b0;
            sel_q     <= 4'd0;
            off_q     <= 6'd0;
            wdat_q    <= 32'd0;
            ack_q     <= 1'b0;
            rdat_q    <= 32'd0;
            en_q      <= 1'b0;
            per_q     <= 1'b0;
            ie_q      <= 1'b0;
            pend_q    <= 1'b0;
            compare_q <= 32'hFFFF_FFFF;
            count_q   <= 32'd0;
            scratch_q <= 32'd0;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            we_q      <= we_d;
            sel_q     <= sel_d;
            off_q     <= off_d;
            wdat_q    <= wdat_d;
            ack_q     <= ack_d;
            rdat_q    <= rdat_d;
            en_q      <= en_d;
            per_q     <= per_d;
            ie_q      <= ie_d;
            pend_q    <= pend_d;
            compare_q <= compare_d;
            count_q   <= count_d;
            scratch_q <= scratch_d;
            irq_q     <= irq_d;
        end
    end

    assign wb.wb_ack_o = ack_q;
    assign wb.wb_dat_o = rdat_q;
    assign irq_o       = irq_q;

endmodule

// File: tb/tb_user_wb_timer_slave.sv
// Self-checking bench for user_wb_timer_slave: directed scenarios plus random
// bus traffic, compared every cycle against a transaction-level model.
module tb_user_wb_timer_slave;

    localparam int          WS   = 1;
    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam logic [31:0] IDV  = 32'hCA1A_0001;

    logic core_clk  = 1'b0;
    logic core_rstn = 1'b0;
    logic irq_o;

    user_wb_timer_slave_if bus ();

    user_wb_timer_slave #(
        .BASE_ADR   (BASE),
        .WAIT_STATES(WS),
        .ID_VALUE   (IDV)
    ) dut (
        .core_clk (core_clk),
        .core_rstn(core_rstn),
        .wb       (bus),
        .irq_o    (irq_o)
    );

    always #5 core_clk = ~core_clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: registers as plain values, each access tracked by the
    // edge number on which its ack must begin.
    // ------------------------------------------------------------------
    logic [31:0] m_compare, m_count, m_scratch;
    logic        m_en, m_per, m_ie, m_pend;
    int          edge_no;
    logic        acc_on;
    int          acc_ack_edge;
    logic        acc_we;
    logic [3:0]  acc_sel;
    logic [5:0]  acc_off;
    logic [31:0] acc_dat;
    logic        exp_ack = 1'b0;
    logic [31:0] exp_dat = 32'd0;
    logic        exp_irq = 1'b0;

    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] sel);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) r[8*b +: 8] = new_v[8*b +: 8];
        end
        return r;
    endfunction

    function automatic logic [31:0] m_read(input logic [5:0] off);
        case (off)
            6'd0:    return {29'd0, m_ie, m_per, m_en};
            6'd1:    return {30'd0, m_en, m_pend};
            6'd2:    return m_compare;
            6'd3:    return m_count;
            6'd4:    return m_scratch;
            6'd5:    return IDV;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_step();
        logic        req, wr, match;
        logic [31:0] n_count, n_compare, n_scratch, adr;
        logic        n_en, n_per, n_ie, n_pend, new_ack;
        logic [31:0] new_dat;
        if (!core_rstn) begin
            m_en = 0; m_per = 0; m_ie = 0; m_pend = 0;
            m_compare = 32'hFFFF_FFFF; m_count = 0; m_scratch = 0;
            acc_on = 0; exp_ack = 0; exp_dat = 0; exp_irq = 0; edge_no = 0;
            return;
        end
        edge_no++;
        adr = bus.wb_adr_i;
        req = bus.wb_cyc_i && bus.wb_stb_i && ((adr & 32'hFFFF_FF00) == BASE);
        wr  = exp_ack && acc_we;
        match = m_en && (m_count == m_compare);

        n_count = m_count; n_compare = m_compare; n_scratch = m_scratch;
        n_en = m_en; n_per = m_per; n_ie = m_ie; n_pend = m_pend;
        if (m_en) n_count = match ? (m_per ? 32'd0 : m_count) : m_count + 32'd1;
        if (match && !m_per) n_en = 0;
        if (wr) begin
            case (acc_off)
                6'd0: if (acc_sel[0]) begin n_en = acc_dat[0]; n_per = acc_dat[1]; n_ie = acc_dat[2]; end
                6'd1: if (acc_sel[0] && acc_dat[0]) n_pend = 0;
                6'd2: n_compare = merge(m_compare, acc_dat, acc_sel);
                6'd3: n_count   = merge(m_count, acc_dat, acc_sel);
                6'd4: n_scratch = merge(m_scratch, acc_dat, acc_sel);
                default: ;
            endcase
        end
        if (match) n_pend = 1;

        new_ack = 0; new_dat = 0;
        if (exp_ack) begin
            acc_on = 0;
        end else if (acc_on) begin
            if (!(bus.wb_cyc_i && bus.wb_stb_i)) acc_on = 0;
            else if (edge_no == acc_ack_edge) begin new_ack = 1; new_dat = m_read(acc_off); end
        end else if (req) begin
            acc_on = 1; acc_we = bus.wb_we_i; acc_sel = bus.wb_sel_i;
            acc_off = adr[7:2]; acc_dat = bus.wb_dat_i;
            acc_ack_edge = edge_no + WS;
            if (WS == 0) begin new_ack = 1; new_dat = m_read(acc_off); end
        end

        m_count = n_count; m_compare = n_compare; m_scratch = n_scratch;
        m_en = n_en; m_per = n_per; m_ie = n_ie; m_pend = n_pend;
        exp_ack = new_ack; exp_dat = new_dat; exp_irq = n_pend & n_ie;
    endtask

    initial begin
        forever begin
            @(posedge core_clk or negedge core_rstn);
            model_step();
        end
    end

    // Cycle-by-cycle comparison of every output against the model.
    always @(negedge core_clk) begin
        check("cyc_ack", 32'(bus.wb_ack_o), 32'(exp_ack));
        check("cyc_dat", bus.wb_dat_o, exp_dat);
        check("cyc_irq", 32'(irq_o), 32'(exp_irq));
    end

    initial begin
        #800000;
        $display("FAIL watchdog: time limit reached, %0d checks so far", n_checks);
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------
    // Bus driver tasks
    // ------------------------------------------------------------------
    task automatic wb_xfer(input logic [31:0] adr, input logic we, input logic [3:0] sel,
                           input logic [31:0] dat, input int tmo,
                           output logic [31:0] rdat, output logic acked, output int lat);
        @(posedge core_clk); #2;
        bus.wb_cyc_i = 1; bus.wb_stb_i = 1; bus.wb_we_i = we;
        bus.wb_sel_i = sel; bus.wb_adr_i = adr; bus.wb_dat_i = dat;
        acked = 0; lat = 0; rdat = 0;
        for (int i = 1; i <= tmo && !acked; i++) begin
            @(negedge core_clk);
            if (bus.wb_ack_o) begin acked = 1; rdat = bus.wb_dat_o; lat = i; end
        end
        @(posedge core_clk); #2;
        bus.wb_cyc_i = 0; bus.wb_stb_i = 0; bus.wb_we_i = 0;
        $display("xfer adr=0x%08h we=%0d sel=%h wdat=0x%08h acked=%0d rdat=0x%08h lat=%0d",
                 adr, we, sel, dat, acked, rdat, lat);
    endtask

    task automatic wr(input logic [7:0] off, input logic [3:0] sel, input logic [31:0] dat);
        logic [31:0] r; logic a; int l;
        wb_xfer(BASE | 32'(off), 1'b1, sel, dat, 10, r, a, l);
        check("wr_ack", 32'(a), 32'd1);
    endtask

    task automatic rd(input logic [7:0] off, input logic [31:0] exp, input string name);
        logic [31:0] r; logic a; int l;
        wb_xfer(BASE | 32'(off), 1'b0, 4'hF, 32'd0, 10, r, a, l);
        check({name, "_ack"}, 32'(a), 32'd1);
        check(name, r, exp);
    endtask

    task automatic wb_abort(input logic [7:0] off, input logic [31:0] dat);
        logic seen;
        @(posedge core_clk); #2;
        bus.wb_cyc_i = 1; bus.wb_stb_i = 1; bus.wb_we_i = 1;
        bus.wb_sel_i = 4'hF; bus.wb_adr_i = BASE | 32'(off); bus.wb_dat_i = dat;
        @(posedge core_clk); #2;
        bus.wb_stb_i = 0;
        seen = 0;
        repeat (5) begin
            @(negedge core_clk);
            if (bus.wb_ack_o) seen = 1;
        end
        bus.wb_cyc_i = 0; bus.wb_we_i = 0;
        check("abort_no_ack", 32'(seen), 32'd0);
        $display("abort adr=0x%08h wdat=0x%08h acked=%0d", BASE | 32'(off), dat, seen);
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        logic [31:0] r, adr, dat;
        logic        a, we, found;
        logic [3:0]  sel;
        int          l, k;

        bus.wb_cyc_i = 0; bus.wb_stb_i = 0; bus.wb_we_i = 0;
        bus.wb_sel_i = 0; bus.wb_adr_i = 0; bus.wb_dat_i = 0;
        core_rstn = 0;
        repeat (3) @(posedge core_clk);
        #2 core_rstn = 1;
        @(negedge core_clk);
        check("rst_ack", 32'(bus.wb_ack_o), 32'd0);
        check("rst_dat", bus.wb_dat_o, 32'd0);
        check("rst_irq", 32'(irq_o), 32'd0);

        // ID read: latency and single ack pulse
        wb_xfer(BASE | 32'h14, 1'b0, 4'hF, 32'd0, 10, r, a, l);
        check("id_ack", 32'(a), 32'd1);
        check("id_data", r, 32'hCA1A_0001);
        check("id_latency", 32'(l), 32'(WS + 2));
        check("id_single_ack", 32'(bus.wb_ack_o), 32'd0);

        rd(8'h08, 32'hFFFF_FFFF, "rst_compare");
        rd(8'h0C, 32'd0, "rst_count");
        rd(8'h00, 32'd0, "rst_ctrl");

        // Byte-lane write to SCRATCH; out-of-window access ignored
        wr(8'h10, 4'hF, 32'd0);
        wr(8'h10, 4'b0101, 32'hA5A5_A5A5);
        rd(8'h10, 32'h00A5_00A5, "scratch_sel");
        wr(8'h10, 4'h0, 32'hFFFF_FFFF);
        rd(8'h10, 32'h00A5_00A5, "scratch_sel0");
        wb_xfer(32'h3000_0100, 1'b0, 4'hF, 32'd0, 20, r, a, l);
        check("outside_no_ack", 32'(a), 32'd0);

        // One-shot
        wr(8'h08, 4'hF, 32'd5);
        wr(8'h0C, 4'hF, 32'd0);
        wr(8'h00, 4'hF, 32'h5);
        repeat (12) @(posedge core_clk);
        #2 check("oneshot_irq", 32'(irq_o), 32'd1);
        rd(8'h04, 32'h1, "oneshot_status");
        rd(8'h0C, 32'd5, "oneshot_count");
        wr(8'h04, 4'h1, 32'h1);
        check("w1c_irq_low", 32'(irq_o), 32'd0);

        // Periodic, W1C colliding with a match
        wr(8'h08, 4'hF, 32'd3);
        wr(8'h0C, 4'hF, 32'd0);
        wr(8'h00, 4'hF, 32'h7);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(posedge core_clk); #1;
            if (m_count == 0) found = 1;
        end
        check("per_phase_found", 32'(found), 32'd1);
        wr(8'h04, 4'h1, 32'h1);
        check("w1c_vs_match", 32'(irq_o), 32'd1);
        // W1C away from a match: PEND returns exactly one period later
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(posedge core_clk); #1;
            if (m_count == 2) found = 1;
        end
        check("per_phase2_found", 32'(found), 32'd1);
        wr(8'h04, 4'h1, 32'h1);
        check("per_clear0", 32'(irq_o), 32'd0);
        @(posedge core_clk); #2;
        check("per_clear1", 32'(irq_o), 32'd0);
        @(posedge core_clk); #2;
        check("per_reset", 32'(irq_o), 32'd1);

        // Wrap-around
        wr(8'h00, 4'hF, 32'h0);
        wr(8'h08, 4'hF, 32'd1);
        wr(8'h0C, 4'hF, 32'hFFFF_FFFF);
        wr(8'h04, 4'hF, 32'h1);
        wr(8'h00, 4'hF, 32'h1);
        repeat (8) @(posedge core_clk);
        rd(8'h0C, 32'd1, "wrap_count");
        rd(8'h04, 32'h1, "wrap_status");

        // Abort during WAIT
        wr(8'h10, 4'hF, 32'h1122_3344);
        wb_abort(8'h10, 32'hDEAD_BEEF);
        rd(8'h10, 32'h1122_3344, "abort_scratch");

        // Reset during WAIT of a COMPARE write
        @(posedge core_clk); #2;
        bus.wb_cyc_i = 1; bus.wb_stb_i = 1; bus.wb_we_i = 1;
        bus.wb_sel_i = 4'hF; bus.wb_adr_i = BASE | 32'h08; bus.wb_dat_i = 32'h1234_5678;
        @(posedge core_clk); #2;
        core_rstn = 0;
        #1 check("rst_mid_ack", 32'(bus.wb_ack_o), 32'd0);
        bus.wb_cyc_i = 0; bus.wb_stb_i = 0; bus.wb_we_i = 0;
        repeat (2) @(posedge core_clk);
        #2 core_rstn = 1;
        rd(8'h08, 32'hFFFF_FFFF, "rst_mid_compare");
        rd(8'h10, 32'd0, "rst_mid_scratch");

        // Random traffic
        for (int t = 0; t < 300; t++) begin
            repeat ($urandom_range(0, 3)) @(posedge core_clk);
            k   = int'($urandom_range(0, 8));
            adr = BASE | 32'(k * 4) | 32'($urandom_range(0, 3));
            we  = 1'($urandom_range(0, 1));
            sel = 4'($urandom_range(0, 15));
            case (k)
                0:       dat = $urandom & 32'hFFFF_FFF7 | 32'($urandom_range(0, 1) * 8);
                2:       dat = 32'($urandom_range(0, 24));
                3:       dat = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 5))
                                                           : 32'($urandom_range(0, 30));
                default: dat = $urandom;
            endcase
            if ($urandom_range(0, 14) == 0) begin
                wb_abort(8'(k * 4), dat);
            end else if ($urandom_range(0, 9) == 0) begin
                adr = adr + 32'h0000_0100 * 32'($urandom_range(1, 255));
                wb_xfer(adr, we, sel, dat, 6, r, a, l);
                check("rand_outside_no_ack", 32'(a), 32'd0);
            end else begin
                wb_xfer(adr, we, sel, dat, 10, r, a, l);
                check("rand_ack", 32'(a), 32'd1);
            end
        end

        repeat (5) @(posedge core_clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/user_wb_timer_slave.md
# user_wb_timer_slave

Wishbone classic responder in the user project area, the target end of the management core's exported user-project Wishbone bus (mprj_cyc/stb/we/sel/adr/dat, mprj_ack, mprj_dat). Decodes one 256-byte window, answers with a programmable number of wait states, and exposes a control/status register set around a 32-bit compare timer. The timer drives one interrupt line into the management core's user IRQ inputs.

## Interface
- BASE_ADR, 32'h3000_0000, window base; only bits [31:8] are compared.
- WAIT_STATES, 1, cycles inserted between request sampling and ack; legal range 0..15.
- ID_VALUE, 32'hCA1A_0001, constant returned by the ID register.

Ports:
- core_clk  in  1  single clock for all logic.
- core_rstn  in  1  reset, asynchronous assert, active-low.
- wb_cyc_i  in  1  bus cycle valid.
- wb_stb_i  in  1  strobe.
- wb_we_i  in  1  1 = write.
- wb_sel_i  in  4  byte lane enables; bit n selects bits [8n+7:8n].
- wb_adr_i  in  32  byte address.
- wb_dat_i  in  32  write data.
- wb_ack_o  out  1  one-cycle acknowledge.
- wb_dat_o  out  32  read data; valid only while wb_ack_o is high, otherwise 0.
- irq_o  out  1  level interrupt, equal to STATUS.PEND AND CTRL.IE.

## Operation
- Request: wb_cyc_i & wb_stb_i & (wb_adr_i[31:8] == BASE_ADR[31:8]). Requests outside the window are ignored and never acked.
- FSM states:
  - IDLE: on request, latch we/sel/adr/dat. If WAIT_STATES = 0, go to ACK; otherwise load the wait counter with WAIT_STATES and go to WAIT.
  - WAIT: decrement the counter; at 1, go to ACK. If cyc or stb drops, the access is aborted: return to IDLE with no ack and no write.
  - ACK: wb_ack_o = 1 for exactly one cycle. The register write commits at the end of this cycle. Next state is IDLE, so back-to-back accesses are separated by at least one idle cycle.
- Registers (offset = adr[7:0], word-aligned; adr[1:0] are ignored):
  - 0x00 CTRL: [0] EN, [1] PER (0 = one-shot, 1 = periodic), [2] IE. Other bits read 0.
  - 0x04 STATUS: [0] PEND, write 1 to clear. [1] RUN, read-only, mirrors EN.
  - 0x08 COMPARE: 32-bit read/write.
  - 0x0C COUNT: 32-bit read/write; a write loads the counter.
  - 0x10 SCRATCH: 32-bit read/write.
  - 0x14 ID: read-only, returns ID_VALUE.
  - Any other offset in the window: acked, reads 0, writes dropped.
- Byte selects apply to all writable bits. A write with sel = 0 is acked and has no effect.
- Timer, evaluated each cycle while EN = 1:
  - If COUNT == COMPARE: set PEND. If PER = 1, COUNT <- 0. If PER = 0, clear EN and hold COUNT.
  - Otherwise COUNT <- COUNT + 1, wrapping modulo 2^32 (0xFFFF_FFFF -> 0).
- Simultaneous events:
  - A bus write to COUNT wins over increment or reload in the same cycle, but a match in that cycle still sets PEND.
  - A W1C on PEND in the same cycle as a match leaves PEND = 1 (set wins).
  - A bus write to CTRL.EN in the same cycle as a one-shot match: the bus value wins.

## Timing
- Reset values (asynchronous): state IDLE, wb_ack_o 0, wb_dat_o 0, irq_o 0, CTRL 0, PEND 0, COMPARE 0xFFFF_FFFF, COUNT 0, SCRATCH 0.
- Latency: a request sampled at rising edge k gives wb_ack_o high during cycle k+1+WAIT_STATES.
- wb_dat_o and wb_ack_o are registered; no combinational path from bus inputs to outputs.
- irq_o is a registered function of PEND and IE. It rises the cycle after the matching edge and falls the cycle after the W1C ack edge.
- Reset asserted mid-access: wb_ack_o drops immediately, the pending write is lost, and all registers return to reset values.

## Test plan
- Reset, then read ID at 0x3000_0014 with WAIT_STATES=1 -> ack 2 cycles after the strobe is sampled, data 0xCA1A_0001, exactly one ack pulse.
- Write 0xA5A5_A5A5 to SCRATCH with sel=4'b0101, preceded by SCRATCH=0 -> readback 0x00A5_00A5. Access to 0x3000_0100 -> no ack within 20 cycles.
- COMPARE=5, COUNT=0, CTRL=0x5 (EN, IE, one-shot) -> PEND and irq_o set after 5 counts, COUNT holds at 5, RUN=0. Write STATUS=1 -> irq_o low the cycle after ack.
- COMPARE=3, CTRL=0x7 (periodic) -> PEND set every 4 cycles, COUNT sequence 0,1,2,3,0. Issue W1C in the same cycle as a match -> PEND remains 1.
- COUNT=0xFFFF_FFFF, COMPARE=1, EN=1 -> COUNT wraps to 0, then 1, and PEND sets. Drop stb during WAIT on a write -> no ack, register unchanged.
- Assert core_rstn low during WAIT of a COMPARE write -> no ack, COMPARE reads 0xFFFF_FFFF after reset.
